// File: rtl/note_scheduler.sv
// note_scheduler
// Monophonic key scheduler for the digital piano. Samples eight raw key
// levels (C4..C5), picks one note by last-pressed priority, and drives a
// single square-wave tone from one shared programmable half-period divider.
// A silence gap is inserted on every note change so the speaker output never
// sees a truncated or glitched half-period.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   keys     in   [NKEYS-1:0] raw key levels, 1 = pressed, asynchronous to clk
//                 (index 0 = C4 ... index 7 = C5)
//   tone     out  registered square wave for the speaker pin
//   active   out  high while in GAP or PLAY
//   note_idx out  [2:0] current note; holds its last value in IDLE
module note_scheduler #(
    parameter int NKEYS      = 8,
    parameter int CLK_HZ     = 50000000,
    parameter int GAP_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] keys,
    output logic             tone,
    output logic             active,
    output logic [2:0]       note_idx
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        PLAY = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [NKEYS-1:0] ks1, ks, kp;
    logic [NKEYS-1:0] rise, held;
    logic [16:0]      div_cnt, div_nx, half_cur;
    logic [GW-1:0]    gap_cnt, gap_nx;
    logic             tone_nx;
    logic [2:0]       note_nx, new_key, fb_key;
    logic             any_rise, any_held, cur_held;

    // Half-period in clk cycles for each note of the built-in table.
    function automatic logic [16:0] half_of(input logic [2:0] i);
        case (i)
            3'd0:    half_of = 17'(CLK_HZ / (2 * 262));
            3'd1:    half_of = 17'(CLK_HZ / (2 * 294));
            3'd2:    half_of = 17'(CLK_HZ / (2 * 330));
            3'd3:    half_of = 17'(CLK_HZ / (2 * 349));
            3'd4:    half_of = 17'(CLK_HZ / (2 * 392));
            3'd5:    half_of = 17'(CLK_HZ / (2 * 440));
            3'd6:    half_of = 17'(CLK_HZ / (2 * 494));
            default: half_of = 17'(CLK_HZ / (2 * 523));
        endcase
    endfunction

    // Two-flop synchronizer followed by a previous-sample register for edge
    // detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            ks1 <= '0;
            ks  <= '0;
            kp  <= '0;
        end else begin
            ks1 <= keys;
            ks  <= ks1;
            kp  <= ks;
        end
    end

    assign rise     = ks & ~kp;
    assign held     = ks;
    assign any_rise = |rise;
    assign any_held = |held;
    assign cur_held = held[note_idx];
    assign half_cur = half_of(note_idx);

    // New key: highest index among simultaneous rises (later iterations win).
    always_comb begin
        new_key = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (rise[i]) new_key = 3'(i);
        end
    end

    // Fallback key: lowest index still held (descending loop, last hit wins).
    always_comb begin
        fb_key = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (held[i]) fb_key = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            note_idx <= '0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            tone     <= 1'b0;
        end else begin
            state    <= state_nx;
            note_idx <= note_nx;
            div_cnt  <= div_nx;
            gap_cnt  <= gap_nx;
            tone     <= tone_nx;
        end
    end

    // active decodes the state register only, so there is no path from keys.
    assign active = (state != IDLE);

    always_comb begin
        state_nx = state;
        note_nx  = note_idx;
        div_nx   = div_cnt;
        gap_nx   = gap_cnt;
        tone_nx  = tone;
        case (state)
            IDLE: begin
                tone_nx = 1'b0;
                if (any_rise) begin
                    state_nx = PLAY;
                    note_nx  = new_key;
                    div_nx   = '0;
                end
            end
            PLAY: begin
                // A rise takes priority over a release in the same cycle.
                if (any_rise) begin
                    state_nx = GAP;
                    note_nx  = new_key;
                    tone_nx  = 1'b0;
                    gap_nx   = '0;
                end else if (!cur_held && any_held) begin
                    state_nx = GAP;
                    note_nx  = fb_key;
                    tone_nx  = 1'b0;
                    gap_nx   = '0;
                end else if (!cur_held) begin
                    state_nx = IDLE;
                    tone_nx  = 1'b0;
                end else if (div_cnt == half_cur - 17'd1) begin
                    tone_nx = ~tone;
                    div_nx  = '0;
                end else begin
                    div_nx = div_cnt + 17'd1;
                end
            end
            GAP: begin
                tone_nx = 1'b0;
                if (any_rise) begin
                    note_nx = new_key;
                    gap_nx  = '0;
                end else if (!cur_held && any_held) begin
                    note_nx = fb_key;
                    gap_nx  = '0;
                end else if (!cur_held) begin
                    state_nx = IDLE;
                end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_nx = PLAY;
                    div_nx   = '0;
                end else begin
                    gap_nx = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                tone_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Monophonic key scheduler for the digital piano. It samples NKEYS raw key inputs (C4..C5) and picks one note by last-pressed priority.
- It sequences a single shared programmable half-period divider, which replaces one fixed divider per note, and drives one square-wave tone output.
- It inserts a short silence gap on every note change so the speaker output has no glitches.

Parameters:
- NKEYS, 8, number of key inputs. Fixed at 8 for the built-in note table.
- CLK_HZ, 50000000, system clock frequency in Hz. Used to build the half-period table.
- GAP_CYCLES, 50000, length of the silence inserted on a note change, in clk cycles (1 ms at 50 MHz). Must be >= 1.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- keys  input  NKEYS  raw key levels, 1 = pressed; asynchronous to clk. Index 0 = C4 ... index 7 = C5.
- tone  output  1  registered square wave to the speaker pin.
- active  output  1  high while in GAP or PLAY.
- note_idx  output  3  index of the current note; holds its last value in IDLE.

Behaviour:
- Reset (sampled on posedge clk while reset=1):
  - state=IDLE; tone=0; active=0; note_idx=0.
  - Divider counter, gap counter, both sync stages and the previous-key register all = 0.
  - Reset takes effect mid-note with no completion of the current half-period.
- Input path:
  - keys go through a 2-flop synchronizer (ks), then a previous-sample register (kp).
  - rise = ks & ~kp; held = ks.
  - A key change at the pins is acted on 3 clk edges after it is first sampled.
- Half-period table, 17-bit, HALF[i] = CLK_HZ/(2*f_i) with integer division. Frequencies 262,294,330,349,392,440,494,523 Hz give (at 50 MHz) 95419, 85034, 75757, 71633, 63775, 56818, 50607, 47801.
- New-key select: if several bits of rise are set in the same cycle, the highest index wins.
- Fallback select: when the current note is released, the lowest-index held key is chosen.
- FSM states: IDLE, GAP, PLAY.
  - IDLE: tone=0, active=0.
    - Any rise → PLAY; note_idx=new key; divider counter=0; tone=0.
  - PLAY: active=1.
    - Divider counter increments each cycle. When it equals HALF[note_idx]-1, tone toggles and the counter returns to 0. Output period = 2*HALF cycles.
    - rise on any key → GAP; note_idx=new key; tone=0; gap counter=0.
    - Else, if held[note_idx]=0 and other keys are held → GAP; note_idx=fallback; tone=0; gap counter=0.
    - Else, if held[note_idx]=0 and no keys are held → IDLE; tone=0.
  - GAP: tone=0, active=1.
    - Gap counter increments each cycle. When it equals GAP_CYCLES-1 → PLAY with divider counter=0 and tone=0.
    - rise during GAP: note_idx=new key, gap counter restarts at 0.
    - Current note released with others held: note_idx=fallback, gap counter restarts.
    - Current note released with no keys held → IDLE.
- Simultaneous events: a rise on some key and release of the current key in the same cycle are handled as the rise (new key wins).
- Widths: divider counter is 17 bits. Gap counter is clog2(GAP_CYCLES+1) bits. Counters never wrap, because the compare resets them.
- All outputs are registered; there are no combinational paths from keys to any output.

Test Plan:
- Reset, then press keys[5] and hold → after the synchronizer latency: active=1, note_idx=5, tone toggles every 56818 cycles (period 113636). Assert reset for 1 cycle mid-note → next cycle tone=0, active=0, note_idx=0.
- Hold keys[0] playing, then press keys[6] → tone=0 and active=1 for exactly GAP_CYCLES cycles. Then note_idx=6 and the first tone rise occurs 50607 cycles after PLAY entry.
- Hold keys[2] and keys[6], with 6 pressed last and playing → release keys[6] → GAP, then PLAY with note_idx=2 and half-period 75757.
- Press keys[1] and keys[4] in the same cycle from IDLE → note_idx=4, no gap, direct PLAY.
- With GAP_CYCLES=4: press keys[3] during GAP → gap counter restarts, note_idx=3, PLAY begins 4 cycles after that rise. Releasing all keys during GAP → IDLE, tone=0, active=0.
- Release keys[7] in the same cycle as keys[0] rises, with 7 current → GAP with note_idx=0 (rise wins). Release all keys → IDLE with note_idx held at 0.
